// File: rtl/pm_pkg.sv
// Shared constants and types for the pm_demux_1to4 routing block.
package pm_pkg;

    localparam int PM_NUM_CH = 4;
    localparam int PM_CNT_W  = 8;

    typedef logic [1:0] pm_sel_t;

    // Saturating increment used by the optional per-channel transfer counters.
    function automatic logic [PM_CNT_W-1:0] pm_sat_inc(input logic [PM_CNT_W-1:0] v);
        return (v == {PM_CNT_W{1'b1}}) ? v : v + PM_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pm_chan_reg.sv
// One-word holding register with valid flag for a single demux output channel.
// Load and drain may happen in the same cycle without a bubble.
module pm_chan_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             drain_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             ready_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // The upstream only asserts load_i when ready_o is high, so a load never overwrites an undrained word.
    assign ready_o = ~valid_q | drain_ready_i;

    // NOTE: give every always_comb output a default first, otherwise a missed branch infers a latch.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (valid_q && drain_ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; data is reset too so outputs read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pm_demux_1to4.sv
// 1-to-4 valid/ready demultiplexer with a one-word register per output channel.
// Optional macro PM_DEMUX_CNT_EN adds saturating per-channel transfer counters (xfer_cnt).
module pm_demux_1to4
    import pm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  pm_sel_t                 in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data0,
    output logic [WIDTH-1:0]        out_data1,
    output logic [WIDTH-1:0]        out_data2,
    output logic [WIDTH-1:0]        out_data3,
    output logic [PM_NUM_CH-1:0]    out_valid,
    input  logic [PM_NUM_CH-1:0]    out_ready
`ifdef PM_DEMUX_CNT_EN
    ,
    output logic [PM_NUM_CH*PM_CNT_W-1:0] xfer_cnt
`endif
);

    logic [WIDTH-1:0]     chan_data [PM_NUM_CH];
    logic [PM_NUM_CH-1:0] chan_ready;
    logic [PM_NUM_CH-1:0] chan_load;
    logic                 in_xfer;

    // Readiness only looks at the addressed channel, so a full channel never blocks the others.
    assign in_ready = chan_ready[in_sel];
    assign in_xfer  = in_valid & in_ready;

    for (genvar i = 0; i < PM_NUM_CH; i++) begin : g_chan
        assign chan_load[i] = in_xfer & (in_sel == pm_sel_t'(i));

        pm_chan_reg #(.WIDTH(WIDTH)) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .load_i        (chan_load[i]),
            .load_data_i   (in_data),
            .drain_ready_i (out_ready[i]),
            .data_o        (chan_data[i]),
            .valid_o       (out_valid[i]),
            .ready_o       (chan_ready[i])
        );
    end

    assign out_data0 = chan_data[0];
    assign out_data1 = chan_data[1];
    assign out_data2 = chan_data[2];
    assign out_data3 = chan_data[3];

`ifdef PM_DEMUX_CNT_EN
    logic [PM_NUM_CH-1:0] out_xfer;
    logic [PM_CNT_W-1:0]  cnt_q [PM_NUM_CH];

    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < PM_NUM_CH; c++) cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < PM_NUM_CH; c++) begin
                if (out_xfer[c]) cnt_q[c] <= pm_sat_inc(cnt_q[c]);
            end
        end
    end

    for (genvar i = 0; i < PM_NUM_CH; i++) begin : g_cnt
        assign xfer_cnt[i*PM_CNT_W +: PM_CNT_W] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_pm_demux_1to4.sv
// Directed self-checking bench for pm_demux_1to4 (optionally with PM_DEMUX_CNT_EN).
module tb_pm_demux_1to4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = '0;
    logic [1:0] in_sel = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0] out_valid;
    logic [3:0] out_ready = '0;
`ifdef PM_DEMUX_CNT_EN
    logic [31:0] xfer_cnt;
`endif

    int total = 0;
    int bad = 0;

    pm_demux_1to4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PM_DEMUX_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] data_of(input int ch);
        case (ch)
            0: return out_data0;
            1: return out_data1;
            2: return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    logic [1:0] sv [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd0, 2'd3};
    logic [3:0] dv [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};

    initial begin
        // Reset state
        #3;
        check("rst_valid", out_valid, 4'b0000);
        check("rst_data0", out_data0, 4'h0);
        check("rst_data3", out_data3, 4'h0);
        check("rst_ready", in_ready, 1'b1);

        // First word right after reset release
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 4'hA, 4'b0000);
        #1 check("first_ready", in_ready, 1'b1);
        @(negedge clk);
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        check("first_valid", out_valid, 4'b0100);
        check("first_data2", out_data2, 4'hA);

        // Full channel 1 blocks itself but not channel 3
        drive(1'b1, 2'd1, 4'h3, 4'b0000);
        @(negedge clk);
        drive(1'b1, 2'd1, 4'h7, 4'b0000);
        #1 check("hol_ready_ch1", in_ready, 1'b0);
        @(negedge clk);
        check("hol_data1_stable", out_data1, 4'h3);
        check("hol_valid_a", out_valid, 4'b0110);
        drive(1'b1, 2'd3, 4'h9, 4'b0000);
        #1 check("hol_ready_ch3", in_ready, 1'b1);
        @(negedge clk);
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        check("hol_valid_b", out_valid, 4'b1110);
        check("hol_data3", out_data3, 4'h9);
        check("hol_data1_kept", out_data1, 4'h3);

        // Drain everything; data holds its last value
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        @(negedge clk);
        check("drain_valid", out_valid, 4'b0000);
        check("drain_data2_hold", out_data2, 4'hA);

        // Simultaneous drain and load on channel 0
        drive(1'b1, 2'd0, 4'h5, 4'b0000);
        @(negedge clk);
        check("ch0_load5", out_data0, 4'h5);
        drive(1'b1, 2'd0, 4'h6, 4'b0001);
        #1 check("swap_ready", in_ready, 1'b1);
        @(negedge clk);
        check("swap_valid", out_valid, 4'b0001);
        check("swap_data0", out_data0, 4'h6);
        drive(1'b0, 2'd0, 4'h0, 4'b0001);
        @(negedge clk);
        check("swap_drain", out_valid, 4'b0000);

        // Stream of 8 words, all consumers ready
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                check($sformatf("stream_valid_%0d", k - 1), out_valid, 4'b0001 << sv[k - 1]);
                check($sformatf("stream_data_%0d", k - 1), data_of(int'(sv[k - 1])), dv[k - 1]);
            end
            if (k < 8) begin
                drive(1'b1, sv[k], dv[k], 4'b1111);
                #1 check($sformatf("stream_ready_%0d", k), in_ready, 1'b1);
            end else begin
                drive(1'b0, 2'd0, 4'h0, 4'b1111);
            end
            @(negedge clk);
        end
        check("stream_empty", out_valid, 4'b0000);

        // Reset while two channels hold words
        drive(1'b1, 2'd0, 4'h1, 4'b0000);
        @(negedge clk);
        drive(1'b1, 2'd3, 4'h2, 4'b0000);
        @(negedge clk);
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        check("prerst_valid", out_valid, 4'b1001);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 4'b0000);
        check("midrst_data0", out_data0, 4'h0);
        check("midrst_data3", out_data3, 4'h0);
        check("midrst_ready", in_ready, 1'b1);
        #4 rst_n = 1'b1;
        out_ready = 4'b1111;
        @(negedge clk);
        check("postrst_valid_a", out_valid, 4'b0000);
        @(negedge clk);
        check("postrst_valid_b", out_valid, 4'b0000);

`ifdef PM_DEMUX_CNT_EN
        // 300 transfers on channel 0 saturate its counter
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 2'd0, 4'(k), 4'b1111);
            @(negedge clk);
        end
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        @(negedge clk);
        @(negedge clk);
        check("cnt_sat", xfer_cnt, 32'h0000_00FF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
